// File: rtl/knn_attr_sequencer.sv
// Avalon-MM loaded attribute FIFO that streams NUM_ATTR-byte samples to a KNN datapath.
// Build option: define KNN_SEQ_IRQ_EN to store irq_en and drive irq = done && irq_en.
module knn_attr_sequencer #(
    parameter int NUM_ATTR   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  attr_data,
    output logic        attr_valid,
    input  logic        attr_ready,
    output logic        attr_last,
    output logic        irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0] LAST_IDX = 8'(NUM_ATTR - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count;
    logic [7:0]       index_q, index_d;
    logic [15:0]      samples_q, samples_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic             irq_en;
    logic             wr, push_req, push, pop, last_xfer;
    logic             fifo_empty, fifo_full;
    logic             start_cmd, stop_cmd, clear_cmd, ack_done, ack_ovf;
    logic             unused_wdata;

    assign wr        = chipselect & ~write_n;
    assign push_req  = wr && (address == 2'd0);
    assign start_cmd = wr && (address == 2'd1) && writedata[0];
    assign stop_cmd  = wr && (address == 2'd1) && writedata[1];
    assign clear_cmd = wr && (address == 2'd1) && writedata[2];
    assign ack_done  = wr && (address == 2'd3) && writedata[0];
    assign ack_ovf   = wr && (address == 2'd3) && writedata[1];
    assign unused_wdata = ^{writedata[31:8], writedata[3]};

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

    assign attr_valid = (state_q != IDLE) && !fifo_empty;
    assign pop        = attr_valid && attr_ready;
    assign push       = push_req && (!fifo_full || pop);
    assign attr_last  = (index_q == LAST_IDX);
    assign last_xfer  = pop && attr_last;
    assign attr_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        index_d    = index_q;
        samples_d  = samples_q;
        done_d     = done_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
            index_d  = attr_last ? 8'd0 : index_q + 8'd1;
        end
        if (last_xfer) samples_d = samples_q + 16'd1;

        // A completion or a dropped push in the same cycle beats the software acknowledge.
        if (ack_done)  done_d = 1'b0;
        if (ack_ovf)   overflow_d = 1'b0;
        if (last_xfer) done_d = 1'b1;
        if (push_req && !push) overflow_d = 1'b1;

        case (state_q)
            IDLE:     if (start_cmd) state_d = RUN;
            // Stop looks at the index after this cycle's transfer, so a sample boundary
            // reached in the same cycle still stops cleanly.
            RUN:      if (stop_cmd) state_d = (index_d == 8'd0) ? IDLE : STOPPING;
            STOPPING: if (last_xfer) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (clear_cmd) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            index_d  = 8'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            index_q    <= 8'd0;
            samples_q  <= 16'd0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            index_q    <= index_d;
            samples_q  <= samples_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= writedata[7:0];
    end

`ifdef KNN_SEQ_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      irq_en <= 1'b0;
        else if (wr && address == 2'd1)    irq_en <= writedata[3];
    end
    assign irq = done_q & irq_en;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: begin
                readdata[22:16] = 7'(count);
                readdata[4:0]   = {overflow_q, done_q, state_q != IDLE, fifo_full, fifo_empty};
            end
            2'd1:    readdata[3:0]  = {irq_en, 1'b0, state_q};
            2'd2:    readdata[15:0] = samples_q;
            default: readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_knn_attr_sequencer.sv
// Directed plus randomized bench for knn_attr_sequencer against a queue-based reference model.
`timescale 1ns/1ps
module tb_knn_attr_sequencer;
    localparam int NUM_ATTR   = 4;
    localparam int FIFO_DEPTH = 8;
`ifdef KNN_SEQ_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  attr_data;
    logic        attr_valid;
    logic        attr_ready;
    logic        attr_last;
    logic        irq;

    int errors = 0;
    int checks = 0;

    // Reference model: byte queue, sample position, mode 0 idle / 1 run / 2 stopping.
    logic [7:0]  fifo_m[$];
    int          idx_m;
    int          mode_m;
    logic [15:0] samples_m;
    logic        done_m, ovf_m, irq_en_m;

    knn_attr_sequencer #(.NUM_ATTR(NUM_ATTR), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .attr_data(attr_data), .attr_valid(attr_valid), .attr_ready(attr_ready),
        .attr_last(attr_last), .irq(irq)
    );

    always #10 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_reg(input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0: begin
                v[22:16] = 7'(fifo_m.size());
                v[4:0]   = {ovf_m, done_m, mode_m != 0, fifo_m.size() == FIFO_DEPTH, fifo_m.size() == 0};
            end
            2'd1:    begin v[3] = irq_en_m; v[1:0] = 2'(mode_m); end
            2'd2:    v[15:0] = samples_m;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_stream();
        logic v;
        v = (mode_m != 0) && (fifo_m.size() != 0);
        return {21'b0, v, idx_m == NUM_ATTR - 1, done_m & irq_en_m, v ? fifo_m[0] : 8'h00};
    endfunction

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        check(tag, readdata, exp);
    endtask

    // One clock: optional register sweep, drive bus/ready, check stream, advance model and DUT.
    task automatic tick(input bit wr_en, input logic [1:0] a, input logic [31:0] d,
                        input bit rdy, input bit regs);
        bit xfer, full_b;
        int mode_b;
        if (regs) begin
            for (int i = 0; i < 3; i++) begin
                address = 2'(i); chipselect = 1'b1; write_n = 1'b1;
                #1;
                check($sformatf("reg%0d", i), readdata, exp_reg(2'(i)));
            end
        end
        address = a; writedata = d; attr_ready = rdy;
        if (wr_en) begin
            chipselect = 1'b1; write_n = 1'b0;
        end else begin
            chipselect = 1'($urandom_range(0, 1));
            write_n    = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
        end
        #1;
        check("stream", {21'b0, attr_valid, attr_last, irq, attr_valid ? attr_data : 8'h00},
              exp_stream());

        xfer   = (mode_m != 0) && (fifo_m.size() != 0) && rdy;
        full_b = fifo_m.size() >= FIFO_DEPTH;
        mode_b = mode_m;
        if (wr_en && a == 2'd3) begin
            if (d[0]) done_m = 1'b0;
            if (d[1]) ovf_m  = 1'b0;
        end
        if (xfer) begin
            void'(fifo_m.pop_front());
            if (idx_m == NUM_ATTR - 1) begin
                idx_m = 0; samples_m++; done_m = 1'b1;
                if (mode_b == 2) mode_m = 0;
            end else begin
                idx_m++;
            end
        end
        if (wr_en && a == 2'd0) begin
            if (!full_b || xfer) fifo_m.push_back(d[7:0]);
            else                 ovf_m = 1'b1;
        end
        if (wr_en && a == 2'd1) begin
            irq_en_m = IRQ_ON && d[3];
            if (d[2]) begin
                fifo_m.delete(); idx_m = 0; mode_m = 0;
            end else if (d[0] && mode_b == 0) begin
                mode_m = 1;
            end else if (d[1] && mode_b == 1) begin
                mode_m = (idx_m == 0) ? 0 : 2;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; attr_ready = 1'b1; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        fifo_m.delete(); idx_m = 0; mode_m = 0; samples_m = '0;
        done_m = 1'b0; ovf_m = 1'b0; irq_en_m = 1'b0;
        #1;
        check("rst_outputs", {21'b0, attr_valid, attr_last, irq, attr_data}, 32'h0);
        rd_check("rst_reg0", 2'd0, 32'h0000_0001);
        rd_check("rst_reg1", 2'd1, 32'h0);
        rd_check("rst_reg2", 2'd2, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] b, input bit rdy);
        tick(1'b1, 2'd0, {24'h0, b}, rdy, 1'b0);
    endtask

    initial begin
        reset_n = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; attr_ready = 1'b0;
        #3;

        // Basic sample: four bytes streamed in order, last on the fourth.
        do_reset();
        push(8'h11, 1'b1); push(8'h22, 1'b1); push(8'h33, 1'b1); push(8'h44, 1'b1);
        tick(1'b1, 2'd1, 32'h1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
        rd_check("basic_status", 2'd0, 32'h0000_000D);
        rd_check("basic_count", 2'd2, 32'h1);
        tick(1'b1, 2'd1, 32'h2, 1'b1, 1'b1);
        rd_check("basic_idle", 2'd1, 32'h0);

        // Overflow: nine pushes while idle, ninth byte lost.
        do_reset();
        for (int i = 0; i < 9; i++) push(8'(8'h60 + i), 1'b1);
        rd_check("ovf_status", 2'd0, 32'h0008_0012);
        tick(1'b1, 2'd1, 32'h1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) tick(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
        rd_check("ovf_drained", 2'd0, 32'h0000_001D);
        rd_check("ovf_samples", 2'd2, 32'h2);
        tick(1'b1, 2'd3, 32'h2, 1'b1, 1'b1);

        // Stop mid-sample: STOPPING until the fourth transfer.
        do_reset();
        tick(1'b1, 2'd1, 32'h1, 1'b1, 1'b0);
        push(8'hB1, 1'b1); push(8'hB2, 1'b1);
        tick(1'b1, 2'd1, 32'h2, 1'b1, 1'b0);
        rd_check("stop_stopping", 2'd1, 32'h2);
        push(8'hB3, 1'b0); push(8'hB4, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0, 2'd0, 32'h0, 1'(i % 2), 1'b1);
        rd_check("stop_idle", 2'd1, 32'h0);
        rd_check("stop_samples", 2'd2, 32'h1);

        // Backpressure: head held while attr_ready stays low.
        do_reset();
        push(8'hA5, 1'b0); push(8'h5A, 1'b0);
        tick(1'b1, 2'd1, 32'h1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        #1;
        check("stall_data", {23'b0, attr_valid, attr_data}, 32'h1A5);
        for (int i = 0; i < 3; i++) tick(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);

        // Interrupt on sample completion, cleared by done acknowledge.
        do_reset();
        tick(1'b1, 2'd1, 32'h8, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push(8'(8'hC0 + i), 1'b1);
        tick(1'b1, 2'd1, 32'h9, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
        check("irq_set", {31'b0, irq}, {31'b0, IRQ_ON});
        tick(1'b1, 2'd3, 32'h1, 1'b1, 1'b1);
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // Reset after two of four transfers, then a fresh sample from index 0.
        do_reset();
        for (int i = 0; i < 4; i++) push(8'(8'hD0 + i), 1'b1);
        tick(1'b1, 2'd1, 32'h1, 1'b1, 1'b0);
        tick(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        tick(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) push(8'(8'hE0 + i), 1'b1);
        tick(1'b1, 2'd1, 32'h1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
        rd_check("rst_fresh_samples", 2'd2, 32'h1);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            int r;
            bit rdy;
            r   = $urandom_range(0, 99);
            rdy = ($urandom_range(0, 3) != 0);
            if (r < 45)      push(8'($urandom), rdy);
            else if (r < 51) tick(1'b1, 2'd1, {28'h0, 1'($urandom_range(0, 1)), 3'b001}, rdy, n % 5 == 0);
            else if (r < 54) tick(1'b1, 2'd1, 32'h2, rdy, n % 5 == 0);
            else if (r < 55) tick(1'b1, 2'd1, 32'h4, rdy, n % 5 == 0);
            else if (r < 59) tick(1'b1, 2'd3, 32'($urandom_range(0, 3)), rdy, n % 5 == 0);
            else             tick(1'b0, 2'($urandom_range(0, 3)), $urandom, rdy, n % 5 == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/knn_attr_sequencer.md
KNN_ATTR_SEQUENCER -- requirements
Module: knn_attr_sequencer

Interface
REQ-001 SHALL have parameter NUM_ATTR, default 4, attributes per sample (2..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, attribute FIFO depth (power of 2, 2..64).
REQ-003 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports address[1:0], chipselect, write_n, writedata[31:0] as inputs: Avalon-MM slave, zero wait states.
REQ-006 SHALL have port readdata  output  32  combinational read mux; unused bits 0.
REQ-007 SHALL have port attr_data  output  8  FIFO head byte to KNN datapath.
REQ-008 SHALL have port attr_valid  output  1  attr_data valid.
REQ-009 SHALL have port attr_ready  input  1  KNN datapath accepts byte.
REQ-010 SHALL have port attr_last  output  1  byte is last attribute of sample.
REQ-011 SHALL have port irq  output  1  sample-done interrupt.

Function
REQ-012 SHALL accept a write when chipselect && !write_n; reads have no side effects.
REQ-013 SHALL push writedata[7:0] into FIFO on write to address 0.
REQ-014 SHALL return on address 0 read {count[22:16], overflow[4], done[3], busy[2], full[1], empty[0]}.
REQ-015 SHALL decode address 1 writes: bit0 start, bit1 stop, bit2 clear, bit3 irq_en (stored); read returns {irq_en[3], state[1:0]}.
REQ-016 SHALL return a 16-bit samples-sent counter on address 2 read; wraps 0xFFFF->0.
REQ-017 SHALL clear done (and overflow) when address 3 is written with bit0 (bit1) = 1.
REQ-018 SHALL implement states IDLE(0), RUN(1), STOPPING(2).
REQ-019 SHALL go IDLE->RUN on start; start in RUN/STOPPING ignored.
REQ-020 SHALL go RUN->IDLE on stop if attribute index = 0, else RUN->STOPPING.
REQ-021 SHALL go STOPPING->IDLE on the transfer with attr_last = 1.
REQ-022 SHALL drive attr_valid = 1 only in RUN/STOPPING with FIFO non-empty; attr_data = FIFO head, held stable until transfer.
REQ-023 SHALL define a transfer as attr_valid && attr_ready in one cycle; pops FIFO same cycle; one byte per cycle max.
REQ-024 SHALL keep an 8-bit attribute index, incremented per transfer, wrapping NUM_ATTR-1 -> 0; attr_last = (index == NUM_ATTR-1).
REQ-025 SHALL, on transfer with attr_last = 1, set done, increment samples counter next edge.
REQ-026 SHALL, when full, discard pushes and set sticky overflow unless a pop occurs in the same cycle, in which case push accepted.
REQ-027 SHALL, on push to empty FIFO, present byte on attr_data the next cycle (latency 1).
REQ-028 SHALL assert busy = (state != IDLE).
REQ-029 SHALL, on clear, flush FIFO, zero index, enter IDLE, next edge; partial sample abandoned; done, overflow, counter kept. Clear wins over start/stop in same write.

Reset
REQ-030 SHALL on reset_n = 0 set state IDLE, FIFO empty, index 0, counter 0, done 0, overflow 0, irq_en 0.
REQ-031 SHALL hold outputs in reset: attr_valid 0, attr_last 0, attr_data 0, irq 0; readdata per reset register values.
REQ-032 SHALL abandon any in-flight transfer on reset mid-sample; no transfer completes on the release edge.

Configuration
REQ-033 SHALL, with macro KNN_SEQ_IRQ_EN defined, drive irq = done && irq_en (registered-signal level, not pulse).
REQ-034 SHALL, without KNN_SEQ_IRQ_EN, tie irq to 0, ignore irq_en writes, read irq_en as 0; all else identical.

Verification
REQ-035 SHALL cover: push 0x11,0x22,0x33,0x44, start, attr_ready=1 -> 4 transfers in order, attr_last on 0x44 only, done=1, counter=1.
REQ-036 SHALL cover: push 9 bytes with FIFO_DEPTH=8, no start -> count=8, full=1, overflow=1, ninth byte lost.
REQ-037 SHALL cover: start, push 2 bytes, stop, push 2 more with attr_ready toggling -> STOPPING until 4th transfer, then IDLE, counter=1.
REQ-038 SHALL cover: attr_ready=0 for 5 cycles with valid high -> attr_data unchanged, no pop; index unchanged.
REQ-039 SHALL cover: irq_en=1, complete sample -> irq=1 (macro on) / 0 (macro off); write 0x1 to address 3 -> irq=0.
REQ-040 SHALL cover: reset_n low after 2 of 4 transfers -> all outputs reset values; new sample starts at index 0.
